// File: rtl/element_select_scanner.sv
// element_select_scanner
//   Walks the indexed-select queue from index 0 to (latched size - 1), one
//   element per cycle. Each returned element is compared against a latched
//   search key. The block reports how many elements matched, and the index of
//   the first match (FIND_LAST=0) or of the last match (FIND_LAST=1).
//
// Ports
//   clk, rst      rising-edge clock; synchronous active-high reset
//   start         search request, sampled only while idle
//   key           signed search value, latched when start is accepted
//   q_size        signed element count, latched and clamped when start is accepted
//   out_val       queue element for index_out, valid in the same cycle
//   index_out     index driven to the queue
//   busy          high while a search or its result cycle is in progress
//   done          one-cycle pulse; the results are valid in that cycle
//   found         at least one match was seen in the last search
//   match_index   first/last matching index, or -1 when there was no match
//   match_count   number of matching elements, saturating
module element_select_scanner #(
   parameter int MAX_SCAN  = 1024,
   parameter bit FIND_LAST = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [31:0] key,
   input  logic signed [31:0] q_size,
   input  logic signed [31:0] out_val,
   output logic signed [31:0] index_out,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic signed [31:0] match_index,
   output logic [31:0]        match_count
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic signed [31:0] MAX_S     = 32'(MAX_SCAN);
   localparam logic [31:0]        COUNT_SAT = 32'h7FFF_FFFF;

   state_t             state, state_nxt;
   logic signed [31:0] key_r;
   logic signed [31:0] lim;
   logic signed [31:0] lim_c;
   logic               hit;
   logic               last_idx;

   // Negative sizes scan nothing; oversize requests are cut to MAX_SCAN.
   always_comb begin
      lim_c = q_size;
      if (q_size < 0)
         lim_c = '0;
      else if (q_size > MAX_S)
         lim_c = MAX_S;
   end

   assign hit      = (out_val == key_r);
   assign last_idx = (index_out == lim - 32'sd1);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (lim_c > 0) ? SCAN : DONE;
         SCAN: if (last_idx) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         index_out   <= '0;
         key_r       <= '0;
         lim         <= '0;
         found       <= 1'b0;
         match_index <= -32'sd1;
         match_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               index_out <= '0;
               if (start) begin
                  key_r       <= key;
                  lim         <= lim_c;
                  found       <= 1'b0;
                  match_index <= -32'sd1;
                  match_count <= '0;
               end
            end
            SCAN: begin
               if (hit) begin
                  found <= 1'b1;
                  if (match_count != COUNT_SAT)
                     match_count <= match_count + 32'd1;
                  // found is still clear on the first hit of this search
                  if (FIND_LAST || !found)
                     match_index <= index_out;
               end
               if (!last_idx)
                  index_out <= index_out + 32'sd1;
            end
            DONE: index_out <= '0;
            default: index_out <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_element_select_scanner.sv
module tb_element_select_scanner;

   // Three instances: first-match, last-match, and a MAX_SCAN=2 clamp instance.
   localparam int NDUT = 3;
   localparam int MAXS [NDUT] = '{1024, 1024, 2};
   localparam bit FL   [NDUT] = '{1'b0, 1'b1, 1'b0};

   logic               clk, rst;
   logic               start [NDUT];
   logic signed [31:0] key, q_size;
   logic signed [31:0] ov [NDUT], io [NDUT], mi [NDUT];
   logic [31:0]        mc [NDUT];
   logic               busy [NDUT], done [NDUT], found [NDUT];

   logic signed [31:0] mem [16];

   int checks = 0;
   int passes = 0;

   typedef struct {
      int                 lim;
      logic               found;
      logic signed [31:0] mi;
      logic [31:0]        mc;
   } exp_t;
   exp_t sb [$];

   element_select_scanner #(.MAX_SCAN(1024), .FIND_LAST(1'b0)) u_first (
      .clk(clk), .rst(rst), .start(start[0]), .key(key), .q_size(q_size),
      .out_val(ov[0]), .index_out(io[0]), .busy(busy[0]), .done(done[0]),
      .found(found[0]), .match_index(mi[0]), .match_count(mc[0]));

   element_select_scanner #(.MAX_SCAN(1024), .FIND_LAST(1'b1)) u_last (
      .clk(clk), .rst(rst), .start(start[1]), .key(key), .q_size(q_size),
      .out_val(ov[1]), .index_out(io[1]), .busy(busy[1]), .done(done[1]),
      .found(found[1]), .match_index(mi[1]), .match_count(mc[1]));

   element_select_scanner #(.MAX_SCAN(2), .FIND_LAST(1'b0)) u_clamp (
      .clk(clk), .rst(rst), .start(start[2]), .key(key), .q_size(q_size),
      .out_val(ov[2]), .index_out(io[2]), .busy(busy[2]), .done(done[2]),
      .found(found[2]), .match_index(mi[2]), .match_count(mc[2]));

   // Queue model: combinational read of the element addressed by each DUT.
   always_comb begin
      for (int k = 0; k < NDUT; k++) begin
         ov[k] = 32'hDEAD_BEEF;
         if (io[k] >= 0 && io[k] < 16)
            ov[k] = mem[io[k][3:0]];
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input int k, input int q, input logic signed [31:0] kv);
      exp_t e;
      logic signed [31:0] v;
      e.lim   = (q < 0) ? 0 : ((q > MAXS[k]) ? MAXS[k] : q);
      e.found = 1'b0;
      e.mi    = -32'sd1;
      e.mc    = '0;
      for (int i = 0; i < e.lim; i++) begin
         v = (i < 16) ? mem[i] : 32'hDEAD_BEEF;
         if (v == kv) begin
            e.mc = e.mc + 32'd1;
            if (FL[k] || !e.found) e.mi = 32'(i);
            e.found = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic load_mem(input int n, input int vals [16]);
      for (int i = 0; i < 16; i++) mem[i] = (i < n) ? 32'(vals[i]) : 32'sd1000 + 32'(i);
   endtask

   // One search on DUT k. With mid=1, a second start, a new size and a new key
   // are applied during the scan and must all be ignored.
   task automatic run_search(input int k, input int q, input logic signed [31:0] kv,
                             input bit mid, input string name);
      exp_t e, r;
      int   cyc;
      bit   seen;
      e = model(k, q, kv);
      sb.push_back(e);
      @(negedge clk);
      q_size   = 32'(q);
      key      = kv;
      start[k] = 1'b1;
      seen     = 1'b0;
      for (cyc = 0; cyc <= e.lim + 4; cyc++) begin
         @(negedge clk);
         start[k] = 1'b0;
         if (mid && cyc == 1) begin
            start[k] = 1'b1;
            q_size   = 32'sd1;
            key      = mem[0];
         end
         if (done[k]) begin
            seen = 1'b1;
            break;
         end
         checks++;
         if (io[k] !== 32'(cyc) || busy[k] !== 1'b1)
            $display("FAIL %s scan idx dut%0d cyc%0d: got idx=%0d busy=%b, expected idx=%0d busy=1",
                     name, k, cyc, io[k], busy[k], cyc);
         else passes++;
      end
      start[k] = 1'b0;
      checks++;
      if (!seen || cyc != e.lim)
         $display("FAIL %s latency dut%0d: done after %0d cycles (seen=%b), expected %0d",
                  name, k, cyc, seen, e.lim);
      else passes++;
      if (sb.size() == 0) begin
         $display("FAIL %s scoreboard empty", name);
         checks++;
      end else begin
         r = sb.pop_front();
         checks++;
         if (found[k] !== r.found)
            $display("FAIL %s found dut%0d: got %b expected %b", name, k, found[k], r.found);
         else passes++;
         checks++;
         if (mi[k] !== r.mi)
            $display("FAIL %s match_index dut%0d: got %0d expected %0d", name, k, mi[k], r.mi);
         else passes++;
         checks++;
         if (mc[k] !== r.mc)
            $display("FAIL %s match_count dut%0d: got %0d expected %0d", name, k, mc[k], r.mc);
         else passes++;
         // Back in idle: pulse gone, index parked, results held.
         @(negedge clk);
         checks++;
         if ({done[k], busy[k], io[k], found[k], mi[k], mc[k]} !==
             {1'b0, 1'b0, 32'sd0, r.found, r.mi, r.mc})
            $display("FAIL %s post-done dut%0d: got done=%b busy=%b idx=%0d found=%b mi=%0d mc=%0d expected 0 0 0 %b %0d %0d",
                     name, k, done[k], busy[k], io[k], found[k], mi[k], mc[k], r.found, r.mi, r.mc);
         else passes++;
      end
   endtask

   task automatic check_reset_vals(input string name);
      for (int k = 0; k < NDUT; k++) begin
         checks++;
         if ({io[k], busy[k], done[k], found[k], mi[k], mc[k]} !==
             {32'sd0, 1'b0, 1'b0, 1'b0, -32'sd1, 32'd0})
            $display("FAIL %s dut%0d: got idx=%0d busy=%b done=%b found=%b mi=%0d mc=%0d expected 0 0 0 0 -1 0",
                     name, k, io[k], busy[k], done[k], found[k], mi[k], mc[k]);
         else passes++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_reset_vals("reset_idle");
      end
   endtask

   task automatic test_first_match;
      load_mem(4, '{5, 7, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(0, 4, 32'sd5, 1'b0, "first_match");
      run_search(0, 4, 32'sd9, 1'b0, "first_match_tail");
   endtask

   task automatic test_last_match;
      load_mem(4, '{5, 7, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(1, 4, 32'sd5, 1'b0, "last_match");
      load_mem(6, '{-2, 4, -2, -2, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(1, 6, -32'sd2, 1'b0, "last_match_neg");
   endtask

   task automatic test_empty;
      run_search(0, 0, 32'sd5, 1'b0, "size_zero");
      run_search(0, -3, 32'sd5, 1'b0, "size_neg");
   endtask

   task automatic test_ignore_mid;
      load_mem(3, '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(0, 3, 32'sd4, 1'b1, "mid_scan_ignore");
   endtask

   task automatic test_clamp;
      load_mem(5, '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(2, 5, 32'sd3, 1'b0, "clamp_miss");
      run_search(2, 5, 32'sd1, 1'b0, "clamp_hit");
   endtask

   task automatic test_back_to_back;
      load_mem(4, '{3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      run_search(0, 4, 32'sd3, 1'b0, "b2b_a");
      run_search(0, 2, 32'sd4, 1'b0, "b2b_b");
   endtask

   task automatic test_reset_mid_scan;
      bit saw_done;
      load_mem(4, '{5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      saw_done = 1'b0;
      @(negedge clk);
      q_size   = 32'sd4;
      key      = 32'sd5;
      start[0] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("reset_mid_scan");
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done[0]) saw_done = 1'b1;
      end
      checks++;
      if (saw_done || busy[0] !== 1'b0)
         $display("FAIL reset_abort: got done_seen=%b busy=%b expected 0 0", saw_done, busy[0]);
      else passes++;
   endtask

   initial begin
      rst    = 1'b1;
      key    = '0;
      q_size = '0;
      for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset;
      test_first_match;
      test_last_match;
      test_empty;
      test_ignore_mid;
      test_clamp;
      test_back_to_back;
      test_reset_mid_scan;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/element_select_scanner.md
Name: element_select_scanner

Overview:
- Downstream consumer of the indexed-select queue stage.
- On `start`, drives the queue's index input sequentially from 0 to the latched size minus 1 and compares each returned element against a search key.
- Reports the match count and the index of the first (or last) match.
- Used to locate values in the queue without software walking it element by element.

Parameters:
- MAX_SCAN, 1024: upper bound on elements scanned per search; latched size is clamped to this.
- FIND_LAST, 0: 0 = `match_index` reports first match; 1 = reports last match.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a search; sampled only in IDLE.
- key  input  32  signed search value; latched on accepted start.
- q_size  input  32  signed element count from queue stage; latched on accepted start.
- out_val  input  32  signed element returned by queue for `index_out`, valid combinationally in the same cycle.
- index_out  output  32  signed index driven to the queue's index input.
- busy  output  1  high while in SCAN or DONE.
- done  output  1  one-cycle pulse when results are valid.
- found  output  1  at least one match in the last completed search.
- match_index  output  32  signed index of first/last match; -1 when none.
- match_count  output  32  number of matching elements in the last search.

Behaviour:
- Reset, synchronous, checked before all else:
  - state=IDLE.
  - index_out=0, busy=0, done=0, found=0.
  - match_index=-1, match_count=0.
  - Key and size registers cleared.
  - Reset asserted mid-scan aborts the search; no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - index_out held at 0.
  - On start=1: latch key; latch lim = clamp(q_size): negative → 0, > MAX_SCAN → MAX_SCAN, else q_size.
  - Clear found/match_count, set match_index=-1, index_out=0.
  - Next state is SCAN if lim>0, else DONE.
- SCAN, one element per cycle:
  - Compare out_val with latched key, signed equality.
  - On equality: match_count+1 and found=1.
  - match_index updates to index_out if FIND_LAST=1, or if FIND_LAST=0 and this is the first match.
  - If index_out==lim-1 → DONE; otherwise index_out+1.
- DONE:
  - done=1 for exactly one cycle, with results valid in that cycle.
  - index_out returns to 0; next state IDLE.
  - Results hold until the next accepted start or reset.
- Latency: start accepted at edge E; done is high in cycle E+lim+1. For lim=0, done is high in the cycle after acceptance.
- start while busy is ignored and not queued. start held high re-triggers in the IDLE cycle after DONE.
- q_size and key changes during SCAN are ignored (latched values used). Queue contents changing mid-scan are not checked; each element is compared as seen in its cycle.
- match_count saturates at 32'h7FFFFFFF (unreachable with MAX_SCAN ≤ 2^31-1).
- busy = (state != IDLE).

Test Plan:
- Reset, then hold start=0 for 5 cycles → index_out=0, busy=0, done=0, found=0, match_index=-1, match_count=0 throughout.
- Queue [5,7,5,9], q_size=4, key=5, FIND_LAST=0, start one cycle → index_out steps 0,1,2,3; done 5 cycles after start edge; found=1, match_index=0, match_count=2.
- Same stimulus with FIND_LAST=1 → match_index=2, match_count=2.
- q_size=0 (also q_size=-3), start → done next cycle; found=0, match_index=-1, match_count=0; index_out never leaves 0.
- Queue [1,2,3], key=4; change q_size to 1 and pulse start mid-scan → scan still covers 3 elements; second start ignored; found=0, match_index=-1.
- MAX_SCAN=2, q_size=5, key=3 at index 3 → only indices 0,1 driven; found=0. Separately, assert rst during SCAN → next cycle all outputs at reset values and no done pulse.
